s6bit_serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: diff = a - b, with signed overflow flag.

---
 rtl/s6bit_serial_subtractor.sv | 165 ++++++++++++++++
 tb/tb_s6bit_serial_subtractor.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/s6bit_serial_subtractor.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : s6bit_serial_subtractor                                        |
// | Purpose  : Bit-serial two's-complement subtractor, diff = a - b, with a   |
// |            signed overflow flag. One full-adder cell plus a carry flop    |
// |            is reused over WIDTH cycles, LSB first (a + ~b + 1).           |
// | Ports    : clk      - rising-edge clock                                   |
// |            rst      - asynchronous active-high reset                       |
// |            start    - request, sampled only in IDLE                        |
// |            a, b     - minuend / subtrahend, captured on accepted start     |
// |            busy     - high while bits are being processed                  |
// |            done     - one-cycle pulse, diff/overflow valid                 |
// |            diff     - result, held until the next op completes             |
// |            overflow - signed overflow of a - b, held like diff             |
// | Config   : S6SUB_SATURATE_EN - when defined, an overflowing result clamps |
// |            to the signed limit instead of wrapping.                       |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module s6bit_serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  // Holds the WIDTH-1 bits already produced; the bit being computed this
  // cycle is prepended to form the full-width result without an extra shift.
  logic [WIDTH-2:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               ovf_q, ovf_d;

  logic               w_nb;
  logic               w_sum;
  logic               w_cout;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_res_cat;

  always_comb begin
    // Single full-adder cell working on the inverted subtrahend bit.
    w_nb      = ~b_sr_q[0];
    w_sum     = a_sr_q[0] ^ w_nb ^ carry_q;
    w_cout    = (a_sr_q[0] & w_nb) | (a_sr_q[0] & carry_q) | (w_nb & carry_q);
    w_res_cat = {w_sum, res_q};
    // Only meaningful on the MSB cycle: operand signs differ and the result
    // sign disagrees with the minuend sign.
    w_ovf     = (a_sr_q[0] != b_sr_q[0]) && (w_sum != a_sr_q[0]);

    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b1;  // the +1 of a + ~b + 1
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = w_res_cat[WIDTH-1:1];
        carry_d = w_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST_BIT) begin
          // Final carry-out is dropped; it is not a borrow indication.
          ovf_d   = w_ovf;
`ifdef S6SUB_SATURATE_EN
          if (w_ovf) begin
            diff_d = a_sr_q[0] ? C_SAT_MIN : C_SAT_MAX;
          end else begin
            diff_d = w_res_cat;
          end
`else
          diff_d  = w_res_cat;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered off the next state so they line up with it.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign overflow = ovf_q;

`ifndef S6SUB_SATURATE_EN
  // Limits are only consumed by the saturating build.
  logic w_unused_sat;
  assign w_unused_sat = ^{C_SAT_MAX, C_SAT_MIN};
`endif

endmodule
`default_nettype wire

// File: tb/tb_s6bit_serial_subtractor.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_s6bit_serial_subtractor                                     |
// | Purpose  : Self-checking bench for s6bit_serial_subtractor (WIDTH=6).     |
// |            Expected results come from signed integer arithmetic with a   |
// |            range test for overflow; S6SUB_SATURATE_EN selects clamping.   |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_s6bit_serial_subtractor;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         overflow;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Currently held result expected on diff/overflow.
  logic [W-1:0] exp_diff;
  logic         exp_ov;

  logic [W-1:0] hist_a [0:39];
  logic [W-1:0] hist_b [0:39];

  s6bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: exact signed difference, overflow when it leaves the W-bit range.
  function automatic void ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] d, output logic ov);
    int r;
    r  = int'($signed(x)) - int'($signed(y));
    ov = (r > (2**(W-1)) - 1) || (r < -(2**(W-1)));
    d  = r[W-1:0];
`ifdef S6SUB_SATURATE_EN
    if (ov) d = (r > 0) ? W'((2**(W-1)) - 1) : W'(2**(W-1));
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation from IDLE, start accepted at edge k, checked every cycle
  // through k+WIDTH+1; leaves the DUT in IDLE just before edge k+WIDTH+2.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
    logic [W-1:0] nd;
    logic         nov;
    ref_sub(ta, tb_v, nd, nov);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = W'($urandom);  // must not affect the captured operands
    check({tag, " busy@k"}, {busy, done}, 2'b10);
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      check({tag, " shift"}, {busy, done, overflow, diff}, {2'b10, exp_ov, exp_diff});
    end
    @(posedge clk); #1;
    check({tag, " done"}, {busy, done}, 2'b01);
    check({tag, " result"}, {overflow, diff}, {nov, nd});
    exp_diff = nd;
    exp_ov   = nov;
    @(posedge clk); #1;
    check({tag, " idle"}, {busy, done, overflow, diff}, {2'b00, exp_ov, exp_diff});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    exp_diff = '0; exp_ov = 1'b0;
    #1;
    check("reset", {busy, done, overflow, diff}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(6'd5,       6'd3,       "t1 5-3");
    run_op(6'b100000,  6'd1,       "t2 -32-1");
    run_op(6'd31,      6'b111111,  "t3 31-(-1)");
    run_op(6'b111001,  6'b111001,  "t4 -7-(-7)");
    run_op(6'd0,       6'b100000,  "t4 0-(-32)");
    run_op(6'b100000,  6'b100000,  "min-min");
    run_op(6'd31,      6'b100000,  "31-(-32)");
    run_op(6'b111111,  6'b100000,  "-1-(-32)");
    for (int n = 0; n < 16; n++) begin
      logic [W-1:0] ra;
      ra = W'($urandom);
      run_op(ra, (n % 5 == 0) ? ra : W'($urandom), "random");
    end

    // start held high; only IDLE-cycle requests are accepted, every 8 edges.
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      hist_a[c] = a;
      hist_b[c] = b;
      @(posedge clk); #1;
      check("held busy/done", {busy, done}, {((c % 8) <= 5), ((c % 8) == 6)});
      if ((c % 8) == 6) begin
        logic [W-1:0] nd;
        logic         nov;
        ref_sub(hist_a[c-6], hist_b[c-6], nd, nov);
        check("held result", {overflow, diff}, {nov, nd});
        exp_diff = nd;
        exp_ov   = nov;
      end
    end
    start = 1'b0;

    // Make sure there is a non-zero held result before the abort.
    run_op(6'd9, 6'd2, "pre-abort");
    @(negedge clk);
    a = 6'd20; b = 6'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b1;  // off-edge, mid-operation
    #1;
    check("abort outputs", {busy, done, overflow, diff}, '0);
    #2;
    rst = 1'b0;
    exp_diff = '0;
    exp_ov   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("after abort", {busy, done, overflow, diff}, '0);
    end
    run_op(6'd10, 6'd4, "t6 10-4");
    check("t6 value", diff, 6'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
